adv7513_pixel_fetcher: RTL and testbench
========================================

ADV7513_PIXEL_FETCHER -- requirements
Module: adv7513_pixel_fetcher

Interface
REQ-001 SHALL have parameter FRAME_BASE, default 24'h000000, word address of frame buffer start.
REQ-002 SHALL have parameter H_WIDTH, default `VGA_H_WIDTH, pixels per active line.
REQ-003 SHALL have parameter V_WIDTH, default `VGA_V_WIDTH, active lines per frame.
REQ-004 SHALL have parameter BURST, default 64, words per memory read burst; H_WIDTH*V_WIDTH is a multiple of BURST.
REQ-005 SHALL have parameter DEPTH, default 256, pixel FIFO depth (power of two, at least 2*BURST).
REQ-006 SHALL have ports: ADV7513_PCLK  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have ports: RESET  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: FRAME_NEW_EN  in  1  one-cycle frame-start pulse from display timing.
REQ-009 SHALL have ports: DATA_REQ  in  1  pixel pop strobe from display timing.
REQ-010 SHALL have ports: DATA  out  16  RGB565 pixel to display timing.
REQ-011 SHALL have ports: RD_REQ  out  1 / RD_ADDR  out  24 / RD_LEN  out  8  memory burst request.
REQ-012 SHALL have ports: RD_ACK  in  1  request accepted; RD_VALID  in  1 / RD_DATA  in  16  returned words.
REQ-013 SHALL have ports: FIFO_LEVEL  out  log2(DEPTH)+1  occupancy; UNDERFLOW  out  1  sticky error flag.

Function
REQ-014 SHALL run FSM states IDLE, REQ, WAIT_DATA, DONE.
REQ-015 SHALL, on FRAME_NEW_EN in IDLE or DONE, flush FIFO, load address counter with FRAME_BASE, clear burst counter, enter REQ next cycle.
REQ-016 SHALL, in REQ, assert RD_REQ only when DEPTH - FIFO_LEVEL >= BURST and bursts issued < H_WIDTH*V_WIDTH/BURST.
REQ-017 SHALL hold RD_REQ, RD_ADDR, RD_LEN stable until the cycle RD_ACK is high; then deassert RD_REQ and enter WAIT_DATA.
REQ-018 SHALL drive RD_LEN = BURST constantly; RD_ADDR SHALL advance by BURST after each acknowledged burst.
REQ-019 SHALL, in WAIT_DATA, write every RD_VALID word into FIFO and count; after BURST words return to REQ, or DONE if last burst.
REQ-020 SHALL ignore RD_VALID outside WAIT_DATA.
REQ-021 SHALL, when DATA_REQ is high and FIFO non-empty, pop one word; DATA SHALL show it the following cycle (1-cycle latency), holding otherwise.
REQ-022 SHALL, when DATA_REQ is high and FIFO empty, drive DATA = 16'h0000 next cycle and set UNDERFLOW.
REQ-023 SHALL handle simultaneous push and pop in one cycle with FIFO_LEVEL unchanged.
REQ-024 SHALL, on FRAME_NEW_EN during REQ with RD_REQ pending or during WAIT_DATA, set restart flag, complete the handshake, discard remaining burst words, then flush and restart per REQ-015.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH; FIFO_LEVEL SHALL never exceed DEPTH.

Reset
REQ-026 SHALL, on RESET, enter IDLE, set RD_REQ=0, RD_ADDR=FRAME_BASE, DATA=16'h0000, FIFO_LEVEL=0, UNDERFLOW=0, restart flag=0.
REQ-027 SHALL give RESET priority over FRAME_NEW_EN, DATA_REQ, RD_ACK and RD_VALID in the same cycle.
REQ-028 SHALL clear UNDERFLOW only by RESET.

Structure
REQ-029 SHALL take H_WIDTH/V_WIDTH defaults from shared vga_config.inc; no new constants there.
REQ-030 SHALL place the FIFO in sub-module pixel_fifo (sync, single clock, registered read data, level output).

Verification
REQ-031 Reset, FRAME_NEW_EN, RD_ACK after 3 cycles, 64 words -> RD_ADDR 0 then 64; FIFO_LEVEL 64 then 128; stop at DEPTH-free<64.
REQ-032 Full frame 320x240, DATA_REQ per display pattern -> exactly 1200 bursts, last RD_ADDR 0x012BC0, DONE, UNDERFLOW=0, DATA order matches RD_DATA order.
REQ-033 DATA_REQ with FIFO empty -> DATA=0x0000 next cycle, UNDERFLOW=1 until RESET.
REQ-034 FRAME_NEW_EN after 20 of 64 burst words -> remaining 44 discarded, FIFO_LEVEL 0, next RD_ADDR = FRAME_BASE.
REQ-035 RESET asserted with RD_REQ high and FIFO_LEVEL 100 -> next cycle RD_REQ 0, FIFO_LEVEL 0, IDLE.

Source files
------------

// File: rtl/adv7513_pixel_fetcher_pkg.sv
// Shared types and constants for the ADV7513 pixel fetcher.
// The VGA geometry macros normally come from the shared vga_config.inc;
// the guarded fallbacks keep this slice self-contained when that file is
// not on the include path.
`ifndef VGA_H_WIDTH
`define VGA_H_WIDTH 320
`endif
`ifndef VGA_V_WIDTH
`define VGA_V_WIDTH 240
`endif

package adv7513_pixel_fetcher_pkg;

    localparam int PIX_W  = 16;   // RGB565 pixel
    localparam int ADDR_W = 24;   // memory word address
    localparam int LEN_W  = 8;    // burst length field

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DONE
    } fetch_state_e;

    // Bits needed to hold any value in 0..max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/adv7513_pixel_fetcher_pixel_fifo.sv
// Synchronous single-clock pixel FIFO with registered read data and an
// occupancy output. A pop on an empty FIFO returns zero and reports an
// underflow for that cycle; flush empties the FIFO and wins over push/pop.
module pixel_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 256,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [PTR_W:0]   level_o,
    output logic             underflow_o
);

    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty && !flush_i;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push = push_i && (!full || do_pop) && !flush_i;

    assign underflow_o = pop_i && empty && !flush_i;
    assign rd_data_o   = rd_data_q;
    assign level_o     = level_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Pixel storage.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // level define which entries are valid, and a reset here would stop the
        // array from mapping onto block RAM.
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Registered read port: new word on a good pop, zero on underflow, else hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (do_pop) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end else if (underflow_o) begin
            rd_data_q <= '0;
        end
    end

endmodule

// File: rtl/adv7513_pixel_fetcher.sv
// Frame-buffer pixel fetcher for the ADV7513 display path. Issues fixed-length
// memory read bursts to keep a pixel FIFO topped up, and hands pixels to the
// display timing one per DATA_REQ with one cycle of latency.
module adv7513_pixel_fetcher
    import adv7513_pixel_fetcher_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FRAME_BASE = 24'h000000,
    parameter int                H_WIDTH    = `VGA_H_WIDTH,
    parameter int                V_WIDTH    = `VGA_V_WIDTH,
    parameter int                BURST      = 64,
    parameter int                DEPTH      = 256
) (
    input  logic                     ADV7513_PCLK,
    input  logic                     RESET,
    input  logic                     FRAME_NEW_EN,
    input  logic                     DATA_REQ,
    output logic [PIX_W-1:0]         DATA,
    output logic                     RD_REQ,
    output logic [ADDR_W-1:0]        RD_ADDR,
    output logic [LEN_W-1:0]         RD_LEN,
    input  logic                     RD_ACK,
    input  logic                     RD_VALID,
    input  logic [PIX_W-1:0]         RD_DATA,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic                     UNDERFLOW
);

    localparam int TOTAL_BURSTS = (H_WIDTH * V_WIDTH) / BURST;
    localparam int LVL_W        = $clog2(DEPTH) + 1;
    localparam int BC_W         = cnt_width(TOTAL_BURSTS);
    localparam int WC_W         = cnt_width(BURST);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic              rd_req_q, rd_req_d;
    logic              restart_q, restart_d;
    logic              underflow_q, underflow_d;

    logic              fifo_flush, fifo_push, fifo_underflow;
    logic [LVL_W-1:0]  free_words;
    logic              can_issue, discard, last_word;

    assign free_words = LVL_W'(DEPTH) - FIFO_LEVEL;
    assign can_issue  = (free_words >= LVL_W'(BURST))
                     && (burst_cnt_q < BC_W'(TOTAL_BURSTS));
    // Words are dropped from the cycle a restart is requested until the
    // in-flight burst has fully drained.
    assign discard    = restart_q || FRAME_NEW_EN;
    assign last_word  = (word_cnt_q == WC_W'(BURST - 1));

    // Next-state and control decode for the burst fetch FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        burst_cnt_d = burst_cnt_q;
        word_cnt_d  = word_cnt_q;
        rd_req_d    = rd_req_q;
        restart_d   = restart_q;
        underflow_d = underflow_q || fifo_underflow;
        fifo_flush  = 1'b0;
        fifo_push   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (FRAME_NEW_EN) begin
                    fifo_flush  = 1'b1;
                    addr_d      = FRAME_BASE;
                    burst_cnt_d = '0;
                    state_d     = REQ;
                end
            end

            REQ: begin
                if (rd_req_q) begin
                    // Request is held unchanged until accepted; a frame start
                    // seen meanwhile is remembered and acted on after the burst.
                    if (FRAME_NEW_EN) restart_d = 1'b1;
                    if (RD_ACK) begin
                        rd_req_d    = 1'b0;
                        addr_d      = addr_q + ADDR_W'(BURST);
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                        word_cnt_d  = '0;
                        state_d     = WAIT_DATA;
                    end
                end else if (FRAME_NEW_EN) begin
                    // Nothing outstanding: restart the frame immediately.
                    fifo_flush  = 1'b1;
                    addr_d      = FRAME_BASE;
                    burst_cnt_d = '0;
                end else if (can_issue) begin
                    rd_req_d = 1'b1;
                end
            end

            WAIT_DATA: begin
                if (FRAME_NEW_EN) restart_d = 1'b1;
                if (RD_VALID) begin
                    fifo_push = !discard;
                    if (last_word) begin
                        if (discard) begin
                            fifo_flush  = 1'b1;
                            addr_d      = FRAME_BASE;
                            burst_cnt_d = '0;
                            restart_d   = 1'b0;
                            state_d     = REQ;
                        end else if (burst_cnt_q == BC_W'(TOTAL_BURSTS)) begin
                            state_d = DONE;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
        endcase
    end

    // FSM and datapath registers with synchronous reset taking priority.
    always_ff @(posedge ADV7513_PCLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            addr_q      <= FRAME_BASE;
            burst_cnt_q <= '0;
            word_cnt_q  <= '0;
            rd_req_q    <= 1'b0;
            restart_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            burst_cnt_q <= burst_cnt_d;
            word_cnt_q  <= word_cnt_d;
            rd_req_q    <= rd_req_d;
            restart_q   <= restart_d;
            underflow_q <= underflow_d;
        end
    end

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_pixel_fifo (
        .clk_i       (ADV7513_PCLK),
        .rst_i       (RESET),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (RD_DATA),
        .pop_i       (DATA_REQ),
        .rd_data_o   (DATA),
        .level_o     (FIFO_LEVEL),
        .underflow_o (fifo_underflow)
    );

    assign RD_REQ    = rd_req_q;
    assign RD_ADDR   = addr_q;
    assign RD_LEN    = LEN_W'(BURST);
    assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_adv7513_pixel_fetcher.sv
// Scoreboard bench for adv7513_pixel_fetcher: a memory model answers bursts and
// queues expected pixels/addresses; monitors pop and compare as the DUT answers.
module tb_adv7513_pixel_fetcher;
    import adv7513_pixel_fetcher_pkg::*;

    localparam logic [23:0] BASE        = 24'h000400;
    localparam int          HW          = 64;
    localparam int          VW          = 8;
    localparam int          BL          = 64;
    localparam int          DP          = 256;
    localparam int          TOTAL_WORDS = HW * VW;         // 512
    localparam int          N_BURSTS    = TOTAL_WORDS / BL; // 8

    logic        clk = 1'b0;
    logic        reset, frame_new_en, data_req, rd_ack, rd_valid;
    logic [15:0] rd_data, data;
    logic        rd_req, underflow;
    logic [23:0] rd_addr;
    logic [7:0]  rd_len;
    logic [8:0]  fifo_level;

    always #5 clk = ~clk;

    adv7513_pixel_fetcher #(
        .FRAME_BASE (BASE),
        .H_WIDTH    (HW),
        .V_WIDTH    (VW),
        .BURST      (BL),
        .DEPTH      (DP)
    ) dut (
        .ADV7513_PCLK (clk),
        .RESET        (reset),
        .FRAME_NEW_EN (frame_new_en),
        .DATA_REQ     (data_req),
        .DATA         (data),
        .RD_REQ       (rd_req),
        .RD_ADDR      (rd_addr),
        .RD_LEN       (rd_len),
        .RD_ACK       (rd_ack),
        .RD_VALID     (rd_valid),
        .RD_DATA      (rd_data),
        .FIFO_LEVEL   (fifo_level),
        .UNDERFLOW    (underflow)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_pix[$];
    logic [23:0] exp_addr[$];
    int          bursts_done = 0;
    int          acks_given  = 0;
    int          ack_limit   = 1000000;
    int          pix_pushed  = 0;
    int          pause_at    = 0;
    bit          pause_en    = 1'b0;
    bit          paused      = 1'b0;
    bit          mem_discard = 1'b0;
    logic [23:0] last_ack_addr = '0;
    logic [15:0] last_pix = '0;
    bit          req_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] pattern(input logic [23:0] a, input int i);
        return (16'(a[15:0] * 16'd5) + 16'(16'(i) * 16'd3)) ^ 16'hA55A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bursts(input int target, input string name);
        int n = 0;
        while (bursts_done < target && n < 3000) begin
            step();
            n++;
        end
        if (bursts_done < target) begin
            n_checks++;
            $display("FAIL %s: timed out, bursts done %0d, required %0d", name, bursts_done, target);
        end
    endtask

    // Memory model: acks each request 3 cycles after it appears, then returns
    // BL words with periodic gaps; stray RD_VALID words are driven while a
    // request waits, which the DUT must ignore.
    initial begin : mem_model
        int          wait_cnt;
        int          word;
        int          gap;
        bit          in_burst;
        logic [23:0] cur_addr;
        wait_cnt = 0; word = 0; gap = 0; in_burst = 1'b0; cur_addr = '0;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            step();
            if (in_burst) begin
                if (word == BL) begin
                    rd_valid = 1'b0;
                    in_burst = 1'b0;
                    mem_discard = 1'b0;
                    bursts_done++;
                end else if (pause_en && word == pause_at) begin
                    rd_valid = 1'b0;
                    paused = 1'b1;
                end else if (gap == 6) begin
                    rd_valid = 1'b0;
                    gap = 0;
                end else begin
                    paused = 1'b0;
                    gap++;
                    rd_valid = 1'b1;
                    rd_data = pattern(cur_addr, word);
                    if (!mem_discard) begin
                        exp_pix.push_back(rd_data);
                        pix_pushed++;
                    end
                    word++;
                end
            end else if (rd_ack) begin
                rd_ack = 1'b0;
                rd_valid = 1'b0;
                in_burst = 1'b1;
                word = 0;
                gap = 0;
            end else if (rd_req) begin
                wait_cnt++;
                if (acks_given < ack_limit && wait_cnt >= 3) begin
                    rd_ack = 1'b1;
                    rd_valid = 1'b0;
                    cur_addr = rd_addr;
                    last_ack_addr = rd_addr;
                    acks_given++;
                    wait_cnt = 0;
                end else begin
                    rd_valid = 1'b1;
                    rd_data = 16'hDEAD;
                end
            end else begin
                wait_cnt = 0;
                rd_valid = 1'b0;
            end
        end
    end

    // Request monitor: every accepted burst must match the next expected address.
    always @(negedge clk) begin
        if (rd_req && rd_ack) begin
            if (exp_addr.size() == 0) begin
                n_checks++;
                $display("FAIL rd_addr: got unexpected request at 0x%0h, required none", rd_addr);
            end else begin
                check("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
                check("rd_len", 32'(rd_len), 32'(BL));
            end
        end
    end

    // Pixel monitor: a pop sampled at an edge shows its word half a cycle later.
    always @(posedge clk) req_seen <= data_req && !reset;

    always @(negedge clk) begin
        if (req_seen) begin
            if (exp_pix.size() > 0) begin
                last_pix = exp_pix.pop_front();
                check("pixel", 32'(data), 32'(last_pix));
            end else begin
                last_pix = '0;
                check("underflow_data", 32'(data), 32'h0);
                check("underflow_flag", 32'(underflow), 32'h1);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin : stimulus
        int pops_issued;
        int cyc;
        int b0;
        reset = 1'b1; frame_new_en = 1'b0; data_req = 1'b0;
        step(); step();
        check("reset_rd_req", 32'(rd_req), 32'h0);
        check("reset_rd_addr", 32'(rd_addr), 32'(BASE));
        check("reset_data", 32'(data), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        check("reset_underflow", 32'(underflow), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        step();

        // Fill from frame start with no pops: four bursts then stall on space.
        for (int i = 0; i < N_BURSTS; i++) exp_addr.push_back(BASE + 24'(i * BL));
        frame_new_en = 1'b1; step(); frame_new_en = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            wait_bursts(b, "fill_burst");
            check("fill_level", 32'(fifo_level), 32'(b * BL));
        end
        repeat (30) step();
        check("stall_rd_req", 32'(rd_req), 32'h0);
        check("stall_level", 32'(fifo_level), 32'(DP));
        check("stall_pending_bursts", 32'(exp_addr.size()), 32'(N_BURSTS - 4));

        // Drain the whole frame with a pop every other cycle.
        pops_issued = 0;
        cyc = 0;
        while (pops_issued < TOTAL_WORDS && cyc < 6000) begin
            if (cyc[0] && ((pix_pushed - pops_issued > 1) || bursts_done == N_BURSTS)) begin
                data_req = 1'b1;
                pops_issued++;
            end else begin
                data_req = 1'b0;
            end
            step();
            cyc++;
        end
        data_req = 1'b0;
        check("frame_pops_issued", 32'(pops_issued), 32'(TOTAL_WORDS));
        repeat (6) step();
        check("frame_state_done", 32'(dut.state_q), 32'(DONE));
        check("frame_bursts", 32'(bursts_done), 32'(N_BURSTS));
        check("frame_last_addr", 32'(last_ack_addr), 32'(BASE + 24'h0001C0));
        check("frame_underflow", 32'(underflow), 32'h0);
        check("frame_level", 32'(fifo_level), 32'h0);
        check("frame_rd_req", 32'(rd_req), 32'h0);
        check("frame_pix_left", 32'(exp_pix.size()), 32'h0);
        check("data_hold", 32'(data), 32'(last_pix));

        // Pop from an empty FIFO: zero data and a sticky underflow flag.
        data_req = 1'b1; step(); data_req = 1'b0;
        repeat (4) step();
        check("underflow_sticky", 32'(underflow), 32'h1);

        // Restart mid-burst after 20 words: rest of burst discarded, refetch from base.
        b0 = bursts_done;
        exp_addr.push_back(BASE);
        exp_addr.push_back(BASE);
        exp_addr.push_back(BASE + 24'(BL));
        pause_at = 20; pause_en = 1'b1;
        frame_new_en = 1'b1; step(); frame_new_en = 1'b0;
        cyc = 0;
        while (!paused && cyc < 500) begin step(); cyc++; end
        check("paused_reached", 32'(paused), 32'h1);
        check("level_20_words", 32'(fifo_level), 32'd20);
        frame_new_en = 1'b1; mem_discard = 1'b1; exp_pix.delete();
        step();
        frame_new_en = 1'b0; pause_en = 1'b0;
        wait_bursts(b0 + 1, "discard_burst");
        check("level_after_discard", 32'(fifo_level), 32'h0);
        check("underflow_after_restart", 32'(underflow), 32'h1);
        ack_limit = acks_given + 2;
        wait_bursts(b0 + 3, "refill_bursts");
        check("level_two_bursts", 32'(fifo_level), 32'd128);

        // Pop 28 words to leave 100 with a third request held unacknowledged.
        for (int i = 0; i < 28; i++) begin
            data_req = 1'b1; step();
            data_req = 1'b0; step();
        end
        repeat (3) step();
        check("level_100", 32'(fifo_level), 32'd100);
        check("held_rd_req", 32'(rd_req), 32'h1);
        check("held_rd_addr", 32'(rd_addr), 32'(BASE + 24'(2 * BL)));
        repeat (5) step();
        check("held_rd_addr_stable", 32'(rd_addr), 32'(BASE + 24'(2 * BL)));
        check("stray_valid_ignored", 32'(fifo_level), 32'd100);

        // Reset beats a simultaneous frame start and pop.
        reset = 1'b1; data_req = 1'b1; frame_new_en = 1'b1;
        step();
        reset = 1'b0; data_req = 1'b0; frame_new_en = 1'b0;
        exp_pix.delete();
        exp_addr.delete();
        check("rst2_rd_req", 32'(rd_req), 32'h0);
        check("rst2_level", 32'(fifo_level), 32'h0);
        check("rst2_underflow", 32'(underflow), 32'h0);
        check("rst2_data", 32'(data), 32'h0);
        check("rst2_state", 32'(dut.state_q), 32'(IDLE));
        check("rst2_rd_addr", 32'(rd_addr), 32'(BASE));
        ack_limit = 1000000;
        repeat (10) step();
        check("idle_no_request", 32'(rd_req), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
